// File: rtl/matpair_loader.sv
// Assembles a beat stream into two flattened NxN operand matrices for matmat<N>.
// Holds the completed pair with out_valid until out_ready; malformed frames are dropped with a frame_err pulse.
module matpair_loader #(
    parameter int DATA_WIDTH  = 16,
    parameter int MATRIX_SIZE = 3
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [DATA_WIDTH-1:0]                     in_data,
    input  logic                                      in_last,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] matrix_a,
    output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] matrix_b,
    output logic                                      frame_err
);
    localparam int NN   = MATRIX_SIZE * MATRIX_SIZE;
    localparam int IDXW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NN - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t          state;
    logic [IDXW-1:0] idx;
    logic            load_en;
    logic            accept;

    // load_en mirrors "not HOLD" as a register; reset gates it combinationally.
    assign in_ready = load_en & ~rst;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD_A;
            idx       <= '0;
            load_en   <= 1'b1;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            matrix_a  <= '0;
            matrix_b  <= '0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                LOAD_A: begin
                    if (accept) begin
                        matrix_a[idx*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                        if (in_last) begin
                            idx       <= '0;
                            frame_err <= 1'b1;
                        end else if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= LOAD_B;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        matrix_b[idx*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                        if (idx == LAST_IDX && in_last) begin
                            idx       <= '0;
                            state     <= HOLD;
                            load_en   <= 1'b0;
                            out_valid <= 1'b1;
                        end else if (idx == LAST_IDX || in_last) begin
                            // Missing or early last: restart framing, keep partial data.
                            idx       <= '0;
                            state     <= LOAD_A;
                            frame_err <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= LOAD_A;
                        load_en   <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= LOAD_A;
                    idx       <= '0;
                    load_en   <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_matpair_loader.sv
// Self-checking bench for matpair_loader (N=2, 8-bit) against a frame-position reference model.
module tb_matpair_loader;
    localparam int DW = 8;
    localparam int N  = 2;
    localparam int NN = N * N;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     in_data = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [NN*DW-1:0]  matrix_a;
    logic [NN*DW-1:0]  matrix_b;
    logic              frame_err;

    matpair_loader #(.DATA_WIDTH(DW), .MATRIX_SIZE(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .matrix_a(matrix_a), .matrix_b(matrix_b),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: element arrays, position within the current frame, hold/error flags.
    logic [DW-1:0]    ea [NN];
    logic [DW-1:0]    eb [NN];
    int               pos = 0;
    bit               m_hold = 0;
    bit               m_err = 0;
    logic [NN*DW-1:0] cap_a, cap_b;
    int               hold_cycles, err_pulses;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NN*DW-1:0] pack(input logic [DW-1:0] m [NN]);
        logic [NN*DW-1:0] r;
        r = '0;
        for (int i = 0; i < NN; i++) r[i*DW +: DW] = m[i];
        return r;
    endfunction

    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit l, input bit ordy, input bit r);
        bit acc;
        @(negedge clk);
        rst = r; in_valid = v; in_data = d; in_last = l; out_ready = ordy;
        #1;
        check("in_ready", in_ready, !r && !m_hold);
        acc = v && !r && !m_hold;
        @(posedge clk);
        #1;
        m_err = 0;
        if (r) begin
            m_hold = 0;
            pos = 0;
            for (int i = 0; i < NN; i++) begin ea[i] = '0; eb[i] = '0; end
        end else if (m_hold) begin
            if (ordy) m_hold = 0;
        end else if (acc) begin
            if (pos < NN) ea[pos] = d; else eb[pos-NN] = d;
            pos++;
            if (l && pos == 2*NN) begin
                m_hold = 1; pos = 0;
            end else if (l || pos == 2*NN) begin
                m_err = 1; pos = 0;
            end
        end
        check("out_valid", out_valid, m_hold);
        check("frame_err", frame_err, m_err);
        if (m_hold || r) begin
            check("matrix_a", matrix_a, pack(ea));
            check("matrix_b", matrix_b, pack(eb));
        end
        if (frame_err) err_pulses++;
        if (out_valid) begin
            hold_cycles++;
            cap_a = matrix_a;
            cap_b = matrix_b;
        end
    endtask

    // bad_last >= 0 puts in_last on that beat and ends the frame there; missing drops in_last.
    task automatic send_frame(input int base, input int bad_last, input bit missing, input bit gaps);
        for (int i = 0; i < 2*NN; i++) begin
            bit l;
            l = missing ? 1'b0 : (bad_last >= 0 ? (i == bad_last) : (i == 2*NN-1));
            if (gaps) cycle(1'b0, 8'hEE, 1'b1, 1'b1, 1'b0);
            cycle(1'b1, DW'(base + i), l, 1'b1, 1'b0);
            if (bad_last >= 0 && i == bad_last) break;
        end
    endtask

    task automatic clear_counts();
        hold_cycles = 0; err_pulses = 0; cap_a = '0; cap_b = '0;
    endtask

    initial begin
        for (int i = 0; i < NN; i++) begin ea[i] = '0; eb[i] = '0; end
        clear_counts();
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Basic frame
        clear_counts();
        send_frame(1, -1, 0, 0);
        check("basic_a", cap_a, 32'h04030201);
        check("basic_b", cap_b, 32'h08070605);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("basic_hold_len", hold_cycles, 1);

        // Backpressure
        clear_counts();
        send_frame(1, -1, 0, 0);
        for (int k = 0; k < 5; k++) cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("bp_hold_len", hold_cycles, 6);
        check("bp_a", cap_a, 32'h04030201);

        // Input gaps
        clear_counts();
        send_frame(9, -1, 0, 1);
        check("gap_a", cap_a, 32'h0C0B0A09);
        check("gap_b", cap_b, 32'h100F0E0D);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Early last on beat 3 (index 2), then a clean frame
        clear_counts();
        send_frame(1, 2, 0, 0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("early_err", err_pulses, 1);
        check("early_hold", hold_cycles, 0);
        send_frame('h11, -1, 0, 0);
        check("early_next_a", cap_a, 32'h14131211);
        check("early_next_b", cap_b, 32'h18171615);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Missing last, then a clean frame
        clear_counts();
        send_frame('h21, -1, 1, 0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("miss_err", err_pulses, 1);
        check("miss_hold", hold_cycles, 0);
        send_frame('h31, -1, 0, 0);
        check("miss_next_a", cap_a, 32'h34333231);
        check("miss_next_b", cap_b, 32'h38373635);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Reset after 5 accepted beats, then a fresh frame
        clear_counts();
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(8'h41 + i), 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h99, 1'b0, 1'b1, 1'b1);
        check("rst_a", matrix_a, '0);
        check("rst_b", matrix_b, '0);
        send_frame('h51, -1, 0, 0);
        check("rst_next_a", cap_a, 32'h54535251);
        check("rst_next_b", cap_b, 32'h58575655);
        check("rst_err", err_pulses, 0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Randomized traffic: gaps, held out_ready, occasional framing errors and resets
        clear_counts();
        for (int c = 0; c < 3000; c++) begin
            bit v, l, ordy, r;
            v    = ($urandom % 4) != 0;
            l    = (pos == 2*NN-1) ? (($urandom % 8) != 0) : (($urandom % 16) == 0);
            ordy = ($urandom % 3) != 0;
            r    = ($urandom % 250) == 0;
            cycle(v, DW'($urandom), l, ordy, r);
        end
        check("rand_saw_hold", hold_cycles > 0, 1'b1);
        check("rand_saw_err", err_pulses > 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
